lwc_stream_fifo: RTL and testbench
==================================

LWC_STREAM_FIFO -- requirements
Module: lwc_stream_fifo

Interface
REQ-001 Parameter BUSW, 32, output bus width in bits; legal values 8, 16, 32, 64, 128.
REQ-002 Parameter DEPTH, 64, storage in bytes; power of two and a multiple of BUSW/8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_data  input  8  byte to enqueue.
REQ-006 wr_valid  input  1  wr_data is valid.
REQ-007 wr_ready  output  1  the FIFO accepts a byte this cycle.
REQ-008 flush  input  1  single-cycle end-of-stream marker.
REQ-009 out_data  output  BUSW  word of BUSW/8 bytes; the oldest byte is at [BUSW-1:BUSW-8].
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  the consumer accepts the word.
REQ-012 out_last  output  1  the current word is the final word of a flushed stream.
REQ-013 level  output  clog2(DEPTH)+1  number of bytes stored.
REQ-014 word_cnt  output  16  count of words popped since reset; wraps from 0xFFFF to 0.
REQ-015 err_residual  output  1  sticky flag: residual bytes were dropped.

Function
REQ-016 Storage shall be a circular buffer with head and tail pointers of clog2(DEPTH) bits; the pointers wrap modulo DEPTH, and storage contents are never shifted.
REQ-017 Push: when wr_valid && wr_ready, wr_data shall be stored at tail, tail shall increment by 1, and level shall increment by 1.
REQ-018 wr_ready shall be 1 only in state FILL with level < DEPTH; a byte offered while full is neither stored nor dropped and stays pending on the input.
REQ-019 Pop: when out_valid && out_ready, head shall advance by BUSW/8, level shall decrease by BUSW/8, and word_cnt shall increment by 1.
REQ-020 A push and a pop in the same cycle shall both take effect: level' = level + 1 - BUSW/8.
REQ-021 out_valid and out_data shall be combinational from registered state; there is zero-cycle latency from head to the output.
REQ-022 out_valid shall equal (level >= BUSW/8), except in the padded case of REQ-027.
REQ-023 FSM states: FILL, DRAIN.
- FILL -> DRAIN when flush = 1 and level > 0.
- In FILL, flush with level = 0 shall be ignored.
REQ-024 In DRAIN, wr_ready shall be 0 and flush shall be ignored.
REQ-025 out_last shall be 1 only in DRAIN, on the word whose pop leaves level = 0.
REQ-026 DRAIN -> FILL on the handshake of the out_last word.
REQ-027 In DRAIN with 0 < level < BUSW/8, behaviour depends on the configuration (REQ-032, REQ-033).
REQ-028 A byte pushed in the same cycle as flush shall be accepted and included in the stream.

Reset
REQ-029 While rst = 1, the outputs shall hold: head = 0, tail = 0, level = 0, word_cnt = 0, err_residual = 0, state = FILL, out_valid = 0, out_last = 0, wr_ready = 0.
REQ-030 rst asserted mid-stream shall discard all stored bytes immediately; storage contents need not be cleared.
REQ-031 wr_ready shall be 1 on the first clock after rst is released.

Configuration
REQ-032 With macro LWC_FIFO_ZEROFILL_EN defined:
- In the case of REQ-027, out_valid = 1 and out_last = 1.
- out_data carries the remaining bytes in the upper positions, with 0x00 in every missing byte lane.
- The pop sets level = 0, head = tail, and returns the FSM to FILL.
REQ-033 With LWC_FIFO_ZEROFILL_EN undefined:
- In the case of REQ-027, the residual bytes shall be dropped on the next clock.
- level = 0, head = tail, and err_residual is set to 1.
- The FSM returns to FILL and no out_last word is emitted.

Verification (BUSW=32, DEPTH=64)
REQ-034 Push bytes 0x00..0x07, hold out_ready=1 -> words 0x00010203 then 0x04050607; word_cnt=2; level=0.
REQ-035 Push 64 bytes with out_ready=0 -> wr_ready=0 at level=64; one pop -> level=60 and wr_ready=1; push 4 more bytes -> tail wraps and bytes 64..67 pop last in order.
REQ-036 Push 0x10..0x15 with flush asserted on the 0x15 push -> word 0x10111213 with out_last=0; then, with ZEROFILL_EN, 0x14150000 with out_last=1; without ZEROFILL_EN, no second word, err_residual=1, level=0.
REQ-037 At level=8, push and pop in the same cycle -> level=5; word_cnt increments by 1.
REQ-038 Assert rst in DRAIN at level=4 -> out_valid=0, level=0, state FILL, err_residual=0; wr_ready=1 one cycle after release.

Source files
------------

// File: rtl/lwc_stream_fifo_if.sv
// Stream bundle for lwc_stream_fifo: byte-wide push side, BUSW-wide word pop side.
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface lwc_stream_fifo_if #(
    parameter int BUSW = 32
);
    logic [7:0]      wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic            flush;
    logic [BUSW-1:0] out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    modport slave (
        input  wr_data, wr_valid, flush, out_ready,
        output wr_ready, out_data, out_valid, out_last
    );

    modport master (
        output wr_data, wr_valid, flush, out_ready,
        input  wr_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/lwc_stream_fifo.sv
// Byte-in / word-out circular FIFO with flush-driven end-of-stream draining.
// Define LWC_FIFO_ZEROFILL_EN to emit a zero-padded final word instead of dropping residual bytes.
module lwc_stream_fifo #(
    parameter int BUSW  = 32,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    lwc_stream_fifo_if.slave       bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            word_cnt,
    output logic                   err_residual
);
    localparam int BPW = BUSW / 8;
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;

    localparam logic [LW-1:0] BPW_L   = LW'(BPW);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [PW-1:0] BPW_P   = PW'(BPW);

`ifdef LWC_FIFO_ZEROFILL_EN
    localparam bit ZEROFILL = 1'b1;
`else
    localparam bit ZEROFILL = 1'b0;
`endif

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   head, head_nxt;
    logic [PW-1:0]   tail, tail_nxt;
    logic [LW-1:0]   level_nxt;
    logic [15:0]     cnt_nxt;
    logic            err_nxt;
    logic [7:0]      mem [DEPTH];

    logic            residual;
    logic            push;
    logic            pop;

    // Fewer than one word left while draining: padded out or dropped, depending on build.
    assign residual = (state == DRAIN) && (level != '0) && (level < BPW_L);

    assign bus.wr_ready  = !rst && (state == FILL) && (level < DEPTH_L);
    assign bus.out_valid = (level >= BPW_L) || (ZEROFILL && residual);
    assign bus.out_last  = (state == DRAIN) && ((level == BPW_L) || (ZEROFILL && residual));

    assign push = bus.wr_valid && bus.wr_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Oldest byte lands in the top lane; lanes past the stored bytes read as zero when padding.
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < BPW; i++) begin
            if (!ZEROFILL || (LW'(i) < level)) begin
                bus.out_data[BUSW-1-8*i -: 8] = mem[head + PW'(i)];
            end
        end
    end

    // NOTE: every variable gets its hold value first so no path through the block infers a latch.
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        cnt_nxt   = word_cnt;
        err_nxt   = err_residual;
        level_nxt = level + LW'(push) - (pop ? BPW_L : '0);

        if (push) begin
            tail_nxt = tail + 1'b1;
        end
        if (pop) begin
            head_nxt = head + BPW_P;
            cnt_nxt  = word_cnt + 16'd1;
        end

        if (state == FILL) begin
            // Only enter DRAIN if something (including a same-cycle push) is left to drain.
            if (bus.flush && (level_nxt != '0)) begin
                state_nxt = DRAIN;
            end
        end else begin
            if (residual && !ZEROFILL) begin
                level_nxt = '0;
                head_nxt  = tail;
                err_nxt   = 1'b1;
                state_nxt = FILL;
            end else if (pop && bus.out_last) begin
                state_nxt = FILL;
                if (residual) begin
                    level_nxt = '0;
                    head_nxt  = tail;
                end
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FILL;
            head         <= '0;
            tail         <= '0;
            level        <= '0;
            word_cnt     <= '0;
            err_residual <= 1'b0;
        end else begin
            state        <= state_nxt;
            head         <= head_nxt;
            tail         <= tail_nxt;
            level        <= level_nxt;
            word_cnt     <= cnt_nxt;
            err_residual <= err_nxt;
        end
    end

    // NOTE: storage is not reset; head, tail and level alone decide which bytes are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_lwc_stream_fifo.sv
// Self-checking bench for lwc_stream_fifo (BUSW=32, DEPTH=64) against a byte-queue model.
module tb_lwc_stream_fifo;
    localparam int BUSW  = 32;
    localparam int DEPTH = 64;
    localparam int BPW   = BUSW / 8;
`ifdef LWC_FIFO_ZEROFILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [$clog2(DEPTH):0] level;
    logic [15:0]            word_cnt;
    logic                   err_residual;

    lwc_stream_fifo_if #(.BUSW(BUSW)) bus ();

    lwc_stream_fifo #(.BUSW(BUSW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .level        (level),
        .word_cnt     (word_cnt),
        .err_residual (err_residual)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the stored stream as a byte queue plus a draining flag.
    logic [7:0]      m_q[$];
    bit              m_drain = 1'b0;
    bit              m_err   = 1'b0;
    logic [15:0]     m_cnt   = 16'd0;

    logic [BUSW-1:0] obs_words[$];
    bit              obs_last[$];

    function automatic bit m_resid();
        return m_drain && (m_q.size() > 0) && (m_q.size() < BPW);
    endfunction

    function automatic bit exp_wr_ready();
        return !m_drain && (m_q.size() < DEPTH);
    endfunction

    function automatic bit exp_valid();
        return (m_q.size() >= BPW) || (ZF && m_resid());
    endfunction

    function automatic bit exp_last();
        return m_drain && exp_valid() && ((m_q.size() == BPW) || m_resid());
    endfunction

    function automatic logic [BUSW-1:0] exp_data();
        logic [BUSW-1:0] w = '0;
        for (int i = 0; i < BPW; i++) begin
            w = (w << 8) | BUSW'((i < m_q.size()) ? m_q[i] : 8'h00);
        end
        return w;
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_drain = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 16'd0;
    endfunction

    // One clock: drive inputs at negedge, log any word handed over, advance the model at posedge.
    task automatic drive_cycle(input bit wv, input logic [7:0] wd, input bit fl, input bit ordy);
        bit pop, push, was_resid, was_last;
        @(negedge clk);
        bus.wr_valid  = wv;
        bus.wr_data   = wd;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid === 1'b1 && ordy) begin
            obs_words.push_back(bus.out_data);
            obs_last.push_back(bus.out_last);
        end
        pop       = exp_valid() && ordy;
        push      = wv && exp_wr_ready();
        was_resid = m_resid();
        was_last  = exp_last();
        @(posedge clk);
        if (pop) begin
            for (int i = 0; i < BPW && m_q.size() > 0; i++) void'(m_q.pop_front());
            m_cnt++;
        end
        if (push) m_q.push_back(wd);
        if (!m_drain) begin
            if (fl && m_q.size() != 0) m_drain = 1'b1;
        end else if (pop && was_last) begin
            m_drain = 1'b0;
        end else if (!ZF && was_resid) begin
            m_q.delete();
            m_err   = 1'b1;
            m_drain = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", bus.wr_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
        checks++; if (level !== 0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (word_cnt !== 0) begin failures++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
        checks++; if (err_residual !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_residual); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL release_wr_ready got=%b exp=1", bus.wr_ready); end
    endtask

    task automatic test_ordered_words();
        obs_words.delete(); obs_last.delete();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b1);
        repeat (3) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (obs_words.size() != 2) begin failures++; $display("FAIL order_count got=%0d exp=2", obs_words.size()); end
        if (obs_words.size() >= 2) begin
            checks++; if (obs_words[0] !== 32'h00010203) begin failures++; $display("FAIL order_w0 got=%h exp=00010203", obs_words[0]); end
            checks++; if (obs_words[1] !== 32'h04050607) begin failures++; $display("FAIL order_w1 got=%h exp=04050607", obs_words[1]); end
        end
        checks++; if (word_cnt !== 2) begin failures++; $display("FAIL order_word_cnt got=%0d exp=2", word_cnt); end
        checks++; if (level !== 0) begin failures++; $display("FAIL order_level got=%0d exp=0", level); end
    endtask

    task automatic test_full_wrap();
        logic [BUSW-1:0] ew;
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        checks++; if (level !== DEPTH) begin failures++; $display("FAIL full_level got=%0d exp=%0d", level, DEPTH); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready got=%b exp=0", bus.wr_ready); end
        drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++; if (level !== DEPTH) begin failures++; $display("FAIL full_hold_level got=%0d exp=%0d", level, DEPTH); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (level !== DEPTH - BPW) begin failures++; $display("FAIL full_pop_level got=%0d exp=%0d", level, DEPTH - BPW); end
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL full_pop_wr_ready got=%b exp=1", bus.wr_ready); end
        for (int i = DEPTH; i < DEPTH + BPW; i++) drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
        checks++; if (level !== DEPTH) begin failures++; $display("FAIL wrap_level got=%0d exp=%0d", level, DEPTH); end
        obs_words.delete(); obs_last.delete();
        repeat (DEPTH / BPW + 4) drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (obs_words.size() != DEPTH / BPW) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", obs_words.size(), DEPTH / BPW); end
        for (int k = 0; k < obs_words.size() && k < DEPTH / BPW; k++) begin
            ew = '0;
            for (int b = 0; b < BPW; b++) ew = (ew << 8) | BUSW'(8'(BPW + BPW * k + b));
            checks++; if (obs_words[k] !== ew) begin failures++; $display("FAIL wrap_word%0d got=%h exp=%h", k, obs_words[k], ew); end
        end
        checks++; if (level !== 0) begin failures++; $display("FAIL wrap_final_level got=%0d exp=0", level); end
    endtask

    task automatic test_flush_residual();
        logic [BUSW-1:0] ew[$];
        bit              el[$];
        do_reset();
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'h10 + 8'(i), (i == 5), 1'b0);
        checks++; if (level !== 6) begin failures++; $display("FAIL flush_level got=%0d exp=6", level); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL flush_drain_wr_ready got=%b exp=0", bus.wr_ready); end
        obs_words.delete(); obs_last.delete();
        repeat (4) drive_cycle(1'b0, 8'h00, 1'b1, 1'b1);
        ew.push_back(32'h10111213); el.push_back(1'b0);
        if (ZF) begin ew.push_back(32'h14150000); el.push_back(1'b1); end
        checks++; if (obs_words.size() != ew.size()) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", obs_words.size(), ew.size()); end
        foreach (ew[k]) begin
            if (k < obs_words.size()) begin
                checks++; if (obs_words[k] !== ew[k]) begin failures++; $display("FAIL flush_word%0d got=%h exp=%h", k, obs_words[k], ew[k]); end
                checks++; if (obs_last[k] !== el[k]) begin failures++; $display("FAIL flush_last%0d got=%b exp=%b", k, obs_last[k], el[k]); end
            end
        end
        checks++; if (err_residual !== !ZF) begin failures++; $display("FAIL flush_err got=%b exp=%b", err_residual, !ZF); end
        checks++; if (level !== 0) begin failures++; $display("FAIL flush_final_level got=%0d exp=0", level); end
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL flush_refill_wr_ready got=%b exp=1", bus.wr_ready); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < BPW; i++) drive_cycle(1'b1, 8'hA0 + 8'(i), (i == BPW - 1), 1'b0);
        checks++; if (level !== BPW) begin failures++; $display("FAIL middrain_level got=%0d exp=%0d", level, BPW); end
        checks++; if (bus.out_last !== 1'b1) begin failures++; $display("FAIL middrain_last got=%b exp=1", bus.out_last); end
        @(negedge clk);
        bus.wr_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        model_clear();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstdrain_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL rstdrain_out_last got=%b exp=0", bus.out_last); end
        checks++; if (level !== 0) begin failures++; $display("FAIL rstdrain_level got=%0d exp=0", level); end
        checks++; if (err_residual !== 1'b0) begin failures++; $display("FAIL rstdrain_err got=%b exp=0", err_residual); end
        checks++; if (bus.wr_ready !== 1'b0) begin failures++; $display("FAIL rstdrain_wr_ready got=%b exp=0", bus.wr_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin failures++; $display("FAIL rstdrain_release_wr_ready got=%b exp=1", bus.wr_ready); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c0;
        do_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        checks++; if (level !== 8) begin failures++; $display("FAIL b2b_pre_level got=%0d exp=8", level); end
        c0 = m_cnt;
        drive_cycle(1'b1, 8'h55, 1'b0, 1'b1);
        checks++; if (level !== 5) begin failures++; $display("FAIL b2b_level got=%0d exp=5", level); end
        checks++; if (word_cnt !== c0 + 16'd1) begin failures++; $display("FAIL b2b_word_cnt got=%0d exp=%0d", word_cnt, c0 + 16'd1); end
    endtask

    task automatic test_random();
        bit wv, fl, ordy;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            wv   = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 15) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            drive_cycle(wv, 8'($urandom), fl, ordy);
            checks++; if (bus.wr_ready !== exp_wr_ready()) begin failures++; $display("FAIL rnd_wr_ready cyc=%0d got=%b exp=%b", n, bus.wr_ready, exp_wr_ready()); end
            checks++; if (bus.out_valid !== exp_valid()) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", n, bus.out_valid, exp_valid()); end
            checks++; if (bus.out_last !== exp_last()) begin failures++; $display("FAIL rnd_out_last cyc=%0d got=%b exp=%b", n, bus.out_last, exp_last()); end
            if (exp_valid()) begin
                checks++; if (bus.out_data !== exp_data()) begin failures++; $display("FAIL rnd_out_data cyc=%0d got=%h exp=%h", n, bus.out_data, exp_data()); end
            end
            checks++; if (level !== m_q.size()) begin failures++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", n, level, m_q.size()); end
            checks++; if (word_cnt !== m_cnt) begin failures++; $display("FAIL rnd_word_cnt cyc=%0d got=%0d exp=%0d", n, word_cnt, m_cnt); end
            checks++; if (err_residual !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", n, err_residual, m_err); end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_ordered_words();
        test_full_wrap();
        test_flush_residual();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
